lsu_align: RTL and testbench
============================

Name: lsu_align

Overview:
- Load/store unit between the MEM pipeline stage and data_mem.
- Accepts one load or store request at a time with a valid/ready handshake and drives the data_mem ports (addr, in, MemLen, MemRead, MemWrite).
- Aligned accesses pass through as a single access. Misaligned halfword/word accesses are split into sequential byte accesses; load results are reassembled and sign/zero extended before a single response pulse.

Parameters:
ADDR_W, 8, byte address width; must match data_mem addr width.

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
req_valid  in  1  request present
req_ready  out  1  block can accept a request
req_write  in  1  1 = store, 0 = load
req_len  in  3  [1:0]: 01 byte, 10 half, 11 word; [2]: 1 = unsigned load
req_addr  in  ADDR_W  byte address
req_wdata  in  32  store data, LSB-aligned
rsp_valid  out  1  one-cycle completion pulse (loads and stores)
rsp_rdata  out  32  extended load data
mem_addr  out  ADDR_W  to data_mem addr
mem_in  out  32  to data_mem in
mem_len  out  3  to data_mem MemLen
mem_read  out  1  to data_mem MemRead
mem_write  out  1  to data_mem MemWrite
mem_out  in  32  from data_mem out (combinational read, extended by data_mem)

Behaviour:
- Reset (async, rst_n=0):
  - State returns to IDLE.
  - req_ready=1 once out of reset; rsp_valid=0; rsp_rdata=0.
  - mem_addr=0, mem_in=0, mem_len=0, mem_read=0, mem_write=0.
- All mem_* outputs are driven from registered state only; there is no combinational path from req_* to mem_*.
- FSM states: IDLE, ACCESS, SPLIT, RESP.
- IDLE:
  - req_ready=1.
  - On req_valid, capture write, len, addr and wdata.
  - Go to ACCESS if aligned; go to SPLIT with byte counter k=0 if misaligned.
  - Misaligned means: half with addr[0]=1, or word with addr[1:0]!=0. Bytes are never misaligned.
- Invalid len ([1:0]=00): no memory access; go directly to RESP with rsp_rdata=0.
- len=111 is treated as a word access (bit 2 ignored).
- req_ready=0 in every state except IDLE; req_valid is ignored there.
- ACCESS (one cycle):
  - mem_addr=addr, mem_len=len, mem_in=wdata.
  - mem_read=!write, mem_write=write.
  - Loads capture mem_out into the result register at the closing edge. Then go to RESP.
- SPLIT (N cycles; N=2 for half, N=4 for word):
  - In cycle k: mem_addr=(addr+k) mod 2^ADDR_W, which wraps.
  - Stores: mem_len=001, mem_in={24'b0, wdata[8k+7:8k]}, mem_write=1.
  - Loads: mem_len=101 (unsigned byte), mem_read=1; mem_out[7:0] is written into result byte k at the closing edge.
  - k increments each cycle. After k=N-1, go to RESP.
- RESP (one cycle):
  - rsp_valid=1; go to IDLE.
  - For split loads, rsp_rdata is the assembled value extended per req_len: half with [2]=0 sign-extends bit 15, half with [2]=1 zero-extends; word passes through.
  - For aligned loads, rsp_rdata equals the captured mem_out unchanged.
  - For stores, rsp_rdata holds its previous value.
- rsp_rdata holds between responses.
- Latency (accept edge E0):
  - Aligned: access in cycle after E0; rsp_valid in cycle after E1; req_ready again after E2.
  - Split: N access cycles, then 1 RESP cycle.
- Reset during SPLIT aborts immediately. Already-committed byte writes remain in memory; no rsp_valid is issued.

Test Plan:
- Aligned LW: mem[4..7]=FF,00,00,80 (word 0x800000FF); req_len=011, addr=0x04 -> exactly one cycle with mem_read=1, mem_len=011, mem_addr=0x04; rsp_valid 2 cycles after accept; rsp_rdata=0x800000FF.
- Misaligned LH/LHU: mem[3]=0x34, mem[4]=0xF2; addr=0x03, req_len=010 -> two byte reads at 0x03 and 0x04 with mem_len=101; rsp_rdata=0xFFFFF234. Repeat with req_len=110 -> 0x0000F234.
- Misaligned SW: addr=0x05, wdata=0xAABBCCDD -> four writes with mem_len=001 to 0x05..0x08 with mem_in[7:0]=DD,CC,BB,AA; rsp_valid in cycle 5 after accept; a following aligned-access LW at 0x04 returns 0xBBCCDDxx (xx = prior mem[4]).
- Wrap: LW at addr=0xFE -> reads at 0xFE, 0xFF, 0x00, 0x01 in order; assembled word correct.
- Back-to-back with reset: req_valid held high across three requests -> req_ready low while busy, each request accepted exactly once. Then assert rst_n=0 during SPLIT cycle k=1 -> all outputs 0 immediately, no rsp_valid, req_ready=1 after release.
- Invalid len 000 -> no mem_read/mem_write asserted; rsp_valid one cycle after accept; rsp_rdata=0.

Source files
------------

// File: rtl/lsu_align.sv
// Load/store alignment unit between the MEM stage and data_mem.
// Aligned accesses pass straight through; misaligned half/word accesses become byte sequences.
module lsu_align #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [2:0]        req_len,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  output logic [31:0]       rsp_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_in,
  output logic [2:0]        mem_len,
  output logic              mem_read,
  output logic              mem_write,
  input  logic [31:0]       mem_out
);

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    SPLIT,
    RESP
  } state_t;

  state_t            state, state_nx;
  logic              wr_q;
  logic [2:0]        len_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;
  logic [1:0]        k_q;
  logic [31:0]       asm_q;
  logic [31:0]       rdata_q;

  logic              req_invalid;
  logic              req_misaligned;
  logic [1:0]        last_k;
  logic [31:0]       asm_nx;
  logic [31:0]       split_rdata;

  assign req_invalid    = (req_len[1:0] == 2'b00);
  assign req_misaligned = ((req_len[1:0] == 2'b10) && req_addr[0]) ||
                          ((req_len[1:0] == 2'b11) && (req_addr[1:0] != 2'b00));

  // A split half ends after byte 1; a split word after byte 3.
  assign last_k = (len_q[1:0] == 2'b10) ? 2'd1 : 2'd3;

  // Assembled value including the byte arriving this cycle, so the final
  // split cycle can load the response register directly.
  always_comb begin
    asm_nx = asm_q;
    asm_nx[{k_q, 3'b000} +: 8] = mem_out[7:0];
  end

  always_comb begin
    if (len_q[1:0] == 2'b10) begin
      split_rdata = len_q[2] ? {16'b0, asm_nx[15:0]} : {{16{asm_nx[15]}}, asm_nx[15:0]};
    end else begin
      split_rdata = asm_nx;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // NOTE: every signal assigned in always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE: begin
        if (req_valid) begin
          if (req_invalid)         state_nx = RESP;
          else if (req_misaligned) state_nx = SPLIT;
          else                     state_nx = ACCESS;
        end
      end
      ACCESS:  state_nx = RESP;
      SPLIT:   if (k_q == last_k) state_nx = RESP;
      RESP:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together from pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q    <= 1'b0;
      len_q   <= 3'b000;
      addr_q  <= '0;
      wdata_q <= 32'h0;
      k_q     <= 2'd0;
      asm_q   <= 32'h0;
      rdata_q <= 32'h0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            wr_q    <= req_write;
            len_q   <= req_len;
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
            k_q     <= 2'd0;
            asm_q   <= 32'h0;
            if (req_invalid) rdata_q <= 32'h0;
          end
        end
        ACCESS: begin
          if (!wr_q) rdata_q <= mem_out;
        end
        SPLIT: begin
          k_q <= k_q + 2'd1;
          if (!wr_q) begin
            asm_q <= asm_nx;
            if (k_q == last_k) rdata_q <= split_rdata;
          end
        end
        default: ;
      endcase
    end
  end

  // Memory port decode depends only on registered state, never on req_*.
  always_comb begin
    mem_addr  = '0;
    mem_in    = 32'h0;
    mem_len   = 3'b000;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    case (state)
      ACCESS: begin
        mem_addr  = addr_q;
        mem_in    = wdata_q;
        mem_len   = {len_q[2] & ~(&len_q[1:0]), len_q[1:0]};
        mem_read  = ~wr_q;
        mem_write = wr_q;
      end
      SPLIT: begin
        mem_addr = addr_q + ADDR_W'(k_q);
        if (wr_q) begin
          mem_len   = 3'b001;
          mem_in    = {24'b0, wdata_q[{k_q, 3'b000} +: 8]};
          mem_write = 1'b1;
        end else begin
          mem_len  = 3'b101;
          mem_read = 1'b1;
        end
      end
      default: ;
    endcase
  end

  assign req_ready = (state == IDLE);
  assign rsp_valid = (state == RESP);
  assign rsp_rdata = rdata_q;

endmodule

// File: tb/tb_lsu_align.sv
// Directed bench for lsu_align with a byte-array data_mem model.
// Single requests come from a vector table; back-to-back and reset-abort are hand sequences.
module tb_lsu_align;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_write = 1'b0;
  logic [2:0]  req_len = 3'b000;
  logic [7:0]  req_addr = 8'h00;
  logic [31:0] req_wdata = 32'h0;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic [7:0]  mem_addr;
  logic [31:0] mem_in;
  logic [2:0]  mem_len;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] mem_out;

  always #5 clk = ~clk;

  lsu_align #(.ADDR_W(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_write (req_write),
    .req_len   (req_len),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .mem_addr  (mem_addr),
    .mem_in    (mem_in),
    .mem_len   (mem_len),
    .mem_read  (mem_read),
    .mem_write (mem_write),
    .mem_out   (mem_out)
  );

  // data_mem model: combinational extended read, little-endian write on the clock edge.
  logic [7:0] mem [256];
  logic [7:0] a1, a2, a3;
  logic [7:0] b0, b1, b2, b3;

  always_comb begin
    a1 = mem_addr + 8'd1;
    a2 = mem_addr + 8'd2;
    a3 = mem_addr + 8'd3;
    b0 = mem[mem_addr];
    b1 = mem[a1];
    b2 = mem[a2];
    b3 = mem[a3];
    case (mem_len[1:0])
      2'b01:   mem_out = mem_len[2] ? {24'b0, b0} : {{24{b0[7]}}, b0};
      2'b10:   mem_out = mem_len[2] ? {16'b0, b1, b0} : {{16{b1[7]}}, b1, b0};
      2'b11:   mem_out = {b3, b2, b1, b0};
      default: mem_out = 32'h0;
    endcase
  end

  always @(posedge clk) begin
    if (mem_write) begin
      mem[mem_addr] <= mem_in[7:0];
      if (mem_len[1]) mem[a1] <= mem_in[15:8];
      if (mem_len[1:0] == 2'b11) begin
        mem[a2] <= mem_in[23:16];
        mem[a3] <= mem_in[31:24];
      end
    end
  end

  typedef struct packed {
    logic [7:0]  a;
    logic [2:0]  l;
    logic        r;
    logic        w;
    logic [31:0] d;
  } acc_t;

  acc_t        accq[$];
  logic [31:0] rspq[$];
  int          accepts = 0;

  always @(negedge clk) begin
    if (mem_read || mem_write) accq.push_back('{mem_addr, mem_len, mem_read, mem_write, mem_in});
    if (rsp_valid) rspq.push_back(rsp_rdata);
  end

  always @(posedge clk) begin
    if (req_valid && req_ready) accepts <= accepts + 1;
  end

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    bit          wr;
    logic [2:0]  len;
    logic [7:0]  addr;
    logic [31:0] wdata;
    int          lat;
    int          nacc;
    logic [2:0]  mlen;
    logic [31:0] rdata;
  } vec_t;

  vec_t vecs[18];

  task automatic run_vec(input vec_t v, input int idx);
    int base;
    int lat;
    int got;
    acc_t e;
    @(negedge clk);
    check($sformatf("v%0d ready", idx), 64'(req_ready), 64'(1));
    base      = accq.size();
    req_write = v.wr;
    req_len   = v.len;
    req_addr  = v.addr;
    req_wdata = v.wdata;
    req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    lat = 1;
    while (!rsp_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    check($sformatf("v%0d latency", idx), 64'(lat), 64'(v.lat));
    check($sformatf("v%0d rdata", idx), 64'(rsp_rdata), 64'(v.rdata));
    @(negedge clk);
    check($sformatf("v%0d pulse", idx), 64'(rsp_valid), 64'(0));
    got = accq.size() - base;
    check($sformatf("v%0d accesses", idx), 64'(got), 64'(v.nacc));
    for (int i = 0; i < v.nacc && i < got; i++) begin
      e = accq[base + i];
      check($sformatf("v%0d acc%0d ctl", idx, i), 64'({e.a, e.l, e.r, e.w}),
            64'({v.addr + 8'(i), v.mlen, ~v.wr, v.wr}));
      if (v.wr) begin
        if (v.nacc > 1) check($sformatf("v%0d acc%0d data", idx, i), 64'(e.d), 64'((v.wdata >> (8 * i)) & 32'hFF));
        else            check($sformatf("v%0d acc%0d data", idx, i), 64'(e.d), 64'(v.wdata));
      end
    end
  endtask

  vec_t b2b[3];

  initial begin
    int rbase;
    int busy;
    for (int i = 0; i < 256; i++) mem[i] <= 8'h00;
    mem[8'h03] <= 8'h34;
    mem[8'h04] <= 8'hFF;
    mem[8'h07] <= 8'h80;
    mem[8'hFE] <= 8'h11;
    mem[8'hFF] <= 8'h22;
    mem[8'h00] <= 8'h33;
    mem[8'h01] <= 8'h44;

    //            wr    len     addr   wdata          lat nacc mlen    rdata
    vecs[0]  = '{1'b0, 3'b011, 8'h04, 32'h0,         2, 1, 3'b011, 32'h800000FF};
    vecs[1]  = '{1'b1, 3'b001, 8'h04, 32'h000000F2,  2, 1, 3'b001, 32'h800000FF};
    vecs[2]  = '{1'b0, 3'b010, 8'h03, 32'h0,         3, 2, 3'b101, 32'hFFFFF234};
    vecs[3]  = '{1'b0, 3'b110, 8'h03, 32'h0,         3, 2, 3'b101, 32'h0000F234};
    vecs[4]  = '{1'b1, 3'b011, 8'h05, 32'hAABBCCDD,  5, 4, 3'b001, 32'h0000F234};
    vecs[5]  = '{1'b0, 3'b011, 8'h04, 32'h0,         2, 1, 3'b011, 32'hBBCCDDF2};
    vecs[6]  = '{1'b0, 3'b011, 8'hFE, 32'h0,         5, 4, 3'b101, 32'h44332211};
    vecs[7]  = '{1'b0, 3'b000, 8'h10, 32'h0,         1, 0, 3'b000, 32'h00000000};
    vecs[8]  = '{1'b0, 3'b111, 8'h04, 32'h0,         2, 1, 3'b011, 32'hBBCCDDF2};
    vecs[9]  = '{1'b0, 3'b111, 8'h05, 32'h0,         5, 4, 3'b101, 32'hAABBCCDD};
    vecs[10] = '{1'b0, 3'b010, 8'h06, 32'h0,         2, 1, 3'b010, 32'hFFFFBBCC};
    vecs[11] = '{1'b0, 3'b001, 8'h07, 32'h0,         2, 1, 3'b001, 32'hFFFFFFBB};
    vecs[12] = '{1'b0, 3'b101, 8'h07, 32'h0,         2, 1, 3'b101, 32'h000000BB};
    vecs[13] = '{1'b1, 3'b010, 8'h20, 32'h1234ABCD,  2, 1, 3'b010, 32'h000000BB};
    vecs[14] = '{1'b1, 3'b010, 8'h21, 32'h00005566,  3, 2, 3'b001, 32'h000000BB};
    vecs[15] = '{1'b0, 3'b011, 8'h20, 32'h0,         2, 1, 3'b011, 32'h005566CD};
    vecs[16] = '{1'b1, 3'b100, 8'h30, 32'h0000FFFF,  1, 0, 3'b000, 32'h00000000};
    vecs[17] = '{1'b0, 3'b010, 8'hFF, 32'h0,         3, 2, 3'b101, 32'h00003322};

    b2b[0] = '{1'b0, 3'b001, 8'h07, 32'h0, 2, 1, 3'b001, 32'hFFFFFFBB};
    b2b[1] = '{1'b0, 3'b110, 8'h03, 32'h0, 3, 2, 3'b101, 32'h0000F234};
    b2b[2] = '{1'b0, 3'b000, 8'h10, 32'h0, 1, 0, 3'b000, 32'h00000000};

    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("reset ready", 64'(req_ready), 64'(1));
    check("reset rsp", 64'({rsp_valid, rsp_rdata}), 64'(0));
    check("reset mem ctl", 64'({mem_addr, mem_len, mem_read, mem_write}), 64'(0));
    check("reset mem_in", 64'(mem_in), 64'(0));

    for (int i = 0; i < 18; i++) run_vec(vecs[i], i);

    // Back-to-back: req_valid stays high; the next request is presented once the previous is taken.
    @(negedge clk);
    rbase     = rspq.size();
    busy      = 0;
    accepts   = 0;
    req_write = b2b[0].wr;
    req_len   = b2b[0].len;
    req_addr  = b2b[0].addr;
    req_wdata = b2b[0].wdata;
    req_valid = 1'b1;
    for (int c = 0; c < 40 && accepts < 3; c++) begin
      @(negedge clk);
      if (!req_ready) busy++;
      if (accepts < 3) begin
        req_write = b2b[accepts].wr;
        req_len   = b2b[accepts].len;
        req_addr  = b2b[accepts].addr;
        req_wdata = b2b[accepts].wdata;
      end
    end
    req_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("b2b accepts", 64'(accepts), 64'(3));
    check("b2b busy cycles", 64'(busy), 64'(6));
    check("b2b responses", 64'(rspq.size() - rbase), 64'(3));
    for (int i = 0; i < 3 && rbase + i < rspq.size(); i++)
      check($sformatf("b2b rdata%0d", i), 64'(rspq[rbase + i]), 64'(b2b[i].rdata));

    // Reset during SPLIT k=1 of a misaligned word store.
    @(negedge clk);
    rbase     = rspq.size();
    req_write = 1'b1;
    req_len   = 3'b011;
    req_addr  = 8'h09;
    req_wdata = 32'h11223344;
    req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    check("abort k1 addr", 64'({mem_addr, mem_write}), 64'({8'h0A, 1'b1}));
    rst_n = 1'b0;
    #1;
    check("abort mem ctl", 64'({mem_addr, mem_len, mem_read, mem_write}), 64'(0));
    check("abort mem_in", 64'(mem_in), 64'(0));
    check("abort rsp", 64'({rsp_valid, rsp_rdata}), 64'(0));
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("abort ready", 64'(req_ready), 64'(1));
    repeat (5) @(negedge clk);
    check("abort no rsp", 64'(rspq.size() - rbase), 64'(0));
    check("abort committed", 64'({mem[8'h08], mem[8'h09], mem[8'h0A], mem[8'h0B]}),
          64'({8'hAA, 8'h44, 8'h00, 8'h00}));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete, limit 200000 reached");
    $fatal(1, "timeout");
  end

endmodule
